// File: rtl/n_way_sum_using_fifos_and_double_buffer_pkg.sv
// Shared helpers for the n-way FIFO-joined adder: result sizing and overflow detection.
package n_way_sum_pkg;

  // Width of the zero-extended sum handed to the overflow helper.
  localparam int unsigned EXT_W = 32;

  // Bits needed to hold the unsigned sum of n_inputs values of width bits each.
  function automatic int unsigned sum_full_width(input int unsigned n_inputs,
                                                 input int unsigned width);
    return width + $clog2(n_inputs);
  endfunction

  // Saturation helper: true when full_sum does not fit in out_w bits.
  function automatic logic sum_overflows(input logic [EXT_W-1:0] full_sum,
                                         input int unsigned      out_w);
    logic ovf;
    if (out_w >= EXT_W) begin
      ovf = 1'b0;
    end else begin
      ovf = ((full_sum >> out_w) != {EXT_W{1'b0}});
    end
    return ovf;
  endfunction

endpackage

// File: rtl/n_way_sum_using_fifos_and_double_buffer_if.sv
// Stream bundle for the n-way adder: n_inputs valid/ready input channels and one output stream.
interface n_way_sum_using_fifos_and_double_buffer_if #(
  parameter int unsigned n_inputs  = 3,
  parameter int unsigned width     = 4,
  parameter int unsigned out_width = 4
);
  logic [n_inputs-1:0]       in_valid;
  logic [n_inputs-1:0]       in_ready;
  logic [n_inputs*width-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [out_width-1:0]      out_data;

  // Producer / consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Adder side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/n_way_sum_using_fifos_and_double_buffer_fifo.sv
// Register-based FIFO with wrap-around pointers and an occupancy counter.
// Depth need not be a power of two. A push while full is dropped even if a
// pop happens in the same cycle, so the caller can gate push with ~o_full.
module flip_flop_fifo_with_counter #(
  parameter int unsigned width = 4,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [width-1:0] i_data,
  input  logic             i_pop,
  output logic [width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CNT_W = $clog2(depth + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(depth - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Data storage; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, counter and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == {CNT_W{1'b0}});
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/n_way_sum_using_fifos_and_double_buffer.sv
// N-way stream joiner: each input channel has its own FIFO; when all FIFOs hold
// data one element is popped from each, summed, and pushed into a 2-entry
// double buffer that drives the back-pressured output stream.
module n_way_sum_using_fifos_and_double_buffer
  import n_way_sum_pkg::*;
#(
  parameter int unsigned n_inputs  = 3,
  parameter int unsigned width     = 4,
  parameter int unsigned depth     = 4,
  parameter int unsigned out_width = 4,
  parameter bit          saturate  = 1'b0
) (
  input logic clk,
  input logic rst,
  n_way_sum_using_fifos_and_double_buffer_if.slave bus
);
  localparam int unsigned FULL_W = sum_full_width(n_inputs, width);

  logic [width-1:0]     w_head [n_inputs];
  logic [n_inputs-1:0]  w_full;
  logic [n_inputs-1:0]  w_empty;
  logic [n_inputs-1:0]  w_push;
  logic                 w_fire;
  logic                 w_out_pop;
  logic [FULL_W-1:0]    w_sum;
  logic [out_width-1:0] w_result;

  // Double buffer: entry 0 is the head presented on the output.
  logic                 r_valid0;
  logic                 r_valid1;
  logic [out_width-1:0] r_buf0;
  logic [out_width-1:0] r_buf1;

  genvar gi;
  generate
    for (gi = 0; gi < n_inputs; gi++) begin : g_chan
      assign w_push[gi] = bus.in_valid[gi] & ~w_full[gi];

      flip_flop_fifo_with_counter #(
        .width (width),
        .depth (depth)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[gi]),
        .i_data  (bus.in_data[gi*width +: width]),
        .i_pop   (w_fire),
        .o_data  (w_head[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi])
      );
    end
  endgenerate

  // Ready depends only on each FIFO's registered full flag (and reset).
  assign bus.in_ready = ~w_full & {n_inputs{~rst}};

  assign w_out_pop = r_valid0 & bus.out_ready;
  // Join when every channel has data and the buffer has room (or frees a slot now).
  assign w_fire    = (&(~w_empty)) & (~r_valid1 | w_out_pop);

  // Adder tree over all FIFO heads at full precision.
  always_comb begin
    w_sum = {FULL_W{1'b0}};
    for (int i = 0; i < n_inputs; i++) begin
      w_sum = w_sum + FULL_W'(w_head[i]);
    end
  end

  // Narrow the sum to the output width, wrapping or clamping on overflow.
  always_comb begin
    if (saturate && sum_overflows(EXT_W'(w_sum), out_width)) begin
      w_result = {out_width{1'b1}};
    end else begin
      w_result = w_sum[out_width-1:0];
    end
  end

  // Double buffer update: push from the join, pop on an output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_buf0   <= {out_width{1'b0}};
      r_buf1   <= {out_width{1'b0}};
    end else begin
      case ({w_fire, w_out_pop})
        2'b11: begin
          if (r_valid1) begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_result;
          end else begin
            r_buf0 <= w_result;
          end
        end
        2'b10: begin
          if (r_valid0) begin
            r_buf1   <= w_result;
            r_valid1 <= 1'b1;
          end else begin
            r_buf0   <= w_result;
            r_valid0 <= 1'b1;
          end
        end
        2'b01: begin
          // Only shift real data forward so out_data holds its last value when idle.
          if (r_valid1) begin
            r_buf0 <= r_buf1;
          end
          r_valid0 <= r_valid1;
          r_valid1 <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid0;
  assign bus.out_data  = r_buf0;

endmodule

// File: tb/tb_n_way_sum_using_fifos_and_double_buffer.sv
// Self-checking bench for the n-way FIFO-joined adder: directed scenarios plus
// randomized traffic scored against per-channel queues.
module tb_n_way_sum_using_fifos_and_double_buffer;
  localparam int N  = 3;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  n_way_sum_using_fifos_and_double_buffer_if #(.n_inputs(N), .width(W), .out_width(OW)) bus ();
  n_way_sum_using_fifos_and_double_buffer_if #(.n_inputs(N), .width(W), .out_width(4))  bus_s ();
  n_way_sum_using_fifos_and_double_buffer_if #(.n_inputs(N), .width(W), .out_width(6))  bus_w ();

  n_way_sum_using_fifos_and_double_buffer #(
    .n_inputs(N), .width(W), .depth(D), .out_width(OW), .saturate(1'b0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  n_way_sum_using_fifos_and_double_buffer #(
    .n_inputs(N), .width(W), .depth(D), .out_width(4), .saturate(1'b1)
  ) dut_sat (.clk(clk), .rst(rst), .bus(bus_s));

  n_way_sum_using_fifos_and_double_buffer #(
    .n_inputs(N), .width(W), .depth(D), .out_width(6), .saturate(1'b0)
  ) dut_wide (.clk(clk), .rst(rst), .bus(bus_w));

  // The two overflow-variant instances see the same input stream and never stall.
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.out_ready = 1'b1;
  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.in_data   = bus.in_data;
  assign bus_w.out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int q [N][$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the k-th output is the wrapped sum of the k-th accepted element of every channel.
  always @(negedge clk) begin
    int  v [N];
    bool_blk: begin
      bit have_all;
      if (rst) begin
        for (int i = 0; i < N; i++) q[i].delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          have_all = 1'b1;
          for (int i = 0; i < N; i++) if (q[i].size() == 0) have_all = 1'b0;
          if (!have_all) begin
            check_eq("monitor_spurious_output", bus.out_valid, 0);
          end else begin
            int s;
            s = 0;
            for (int i = 0; i < N; i++) begin
              v[i] = q[i].pop_front();
              s += v[i];
            end
            check_eq("stream_sum", bus.out_data, s % (1 << OW));
            n_out++;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (bus.in_valid[i] && bus.in_ready[i]) q[i].push_back(int'(bus.in_data[i*W +: W]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    tick();
    #3 rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    do_reset();
    bus.in_data   = {4'd3, 4'd2, 4'd1};
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b1;
    tick();
    check_eq("b2b_valid_after_accept_edge", bus.out_valid, 0);
    tick();
    check_eq("b2b_valid_second_edge", bus.out_valid, 1);
    check_eq("b2b_first_sum", bus.out_data, 6);
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid && bus.out_ready) cnt++;
      tick();
    end
    check_eq("b2b_sums_in_22_cycles", cnt, 20);
    bus.in_valid = '0;
    repeat (8) tick();
  endtask

  task automatic test_overflow();
    do_reset();
    bus.in_data   = {4'd15, 4'd15, 4'd15};
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_eq("ovf_wrap_valid", bus.out_valid, 1);
    check_eq("ovf_wrap_data", bus.out_data, 13);
    check_eq("ovf_sat_data", bus_s.out_data, 15);
    check_eq("ovf_wide_data", bus_w.out_data, 45);
    bus.in_valid = '0;
    repeat (8) tick();
  endtask

  task automatic test_missing();
    int e0 [4];
    int e1 [4];
    int e2 [4];
    int got;
    got = 0;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 3'b011;
    for (int k = 0; k < 4; k++) begin
      e0[k] = $urandom_range(0, 15);
      e1[k] = $urandom_range(0, 15);
      bus.in_data = {4'd0, 4'(e1[k]), 4'(e0[k])};
      tick();
    end
    check_eq("miss_in_ready", bus.in_ready, 3'b100);
    check_eq("miss_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 3'b100;
    for (int k = 0; k < 4; k++) begin
      e2[k] = $urandom_range(0, 15);
      bus.in_data = {4'(e2[k]), 8'd0};
      tick();
    end
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (bus.out_valid) begin
        check_eq("miss_drain_sum", bus.out_data, (e0[got] + e1[got] + e2[got]) % 16);
        got++;
      end
      tick();
    end
    check_eq("miss_drain_count", got, 4);
    check_eq("miss_ready_recovered", bus.in_ready, 3'b111);
  endtask

  task automatic test_backpressure();
    int ev [N][8];
    int acc [N];
    int d [N];
    int got;
    got = 0;
    for (int i = 0; i < N; i++) acc[i] = 0;
    do_reset();
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        d[i] = $urandom_range(0, 15);
        bus.in_data[i*W +: W] = 4'(d[i]);
        if (bus.in_ready[i]) begin
          if (acc[i] < 8) ev[i][acc[i]] = d[i];
          acc[i]++;
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) check_eq("bp_accepts_per_channel", acc[i], D + 2);
    check_eq("bp_in_ready_low", bus.in_ready, 0);
    check_eq("bp_out_valid_held", bus.out_valid, 1);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (bus.out_valid) begin
        check_eq("bp_drain_sum", bus.out_data, (ev[0][got] + ev[1][got] + ev[2][got]) % 16);
        got++;
      end
      tick();
    end
    check_eq("bp_drain_count", got, 6);
    repeat (3) tick();
    check_eq("bp_no_duplicate", bus.out_valid, 0);
  endtask

  task automatic test_midreset();
    int seen;
    seen = 0;
    do_reset();
    bus.in_valid  = 3'b111;
    bus.in_data   = 12'($urandom);
    bus.out_ready = 1'b0;
    repeat (4) tick();
    check_eq("midrst_pre_valid", bus.out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid_async", bus.out_valid, 0);
    check_eq("midrst_out_data_async", bus.out_data, 0);
    check_eq("midrst_in_ready_during", bus.in_ready, 0);
    tick();
    bus.in_valid = '0;
    rst = 1'b0;
    #1;
    check_eq("midrst_in_ready_release", bus.in_ready, 3'b111);
    bus.out_ready = 1'b1;
    repeat (6) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check_eq("midrst_no_stale_sum", seen, 0);
  endtask

  task automatic test_random();
    int sent [N];
    int pend [N];
    int start_out;
    int residue;
    bit done;
    do_reset();
    start_out = n_out;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      pend[i] = $urandom_range(0, 15);
    end
    for (int c = 0; c < 4000; c++) begin
      done = 1'b1;
      for (int i = 0; i < N; i++) if (sent[i] < 100 || q[i].size() != 0) done = 1'b0;
      if (done && !bus.out_valid) break;
      for (int i = 0; i < N; i++) begin
        bus.in_valid[i]       = (sent[i] < 100) && ($urandom_range(0, 3) != 0);
        bus.in_data[i*W +: W] = 4'(pend[i]);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if (bus.in_valid[i] && bus.in_ready[i]) begin
          sent[i]++;
          pend[i] = $urandom_range(0, 15);
        end
      end
      tick();
    end
    idle();
    residue = 0;
    for (int i = 0; i < N; i++) residue += q[i].size();
    check_eq("rand_output_count", n_out - start_out, 100);
    check_eq("rand_model_residue", residue, 0);
    check_eq("rand_final_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check_eq("reset_out_valid", bus.out_valid, 0);
    check_eq("reset_in_ready_during", bus.in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("reset_in_ready_release", bus.in_ready, 3'b111);
    check_eq("reset_out_data", bus.out_data, 0);
    test_back_to_back();
    test_overflow();
    test_missing();
    test_backpressure();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n_way_sum_using_fifos_and_double_buffer.md
Name: n_way_sum_using_fifos_and_double_buffer

Overview:
- Generalises the two-operand FIFO-joined adder to n_inputs independent valid/ready input streams.
- Each input stream is buffered in its own FIFO.
- When every FIFO holds data, one element is popped from each, summed, and pushed into a 2-entry double buffer that drives the output stream.
- Output width is configurable, with wrap or saturate on overflow.
- Used as a generic multi-stream joiner/reducer between pipelined producers and a back-pressured consumer.

Parameters:
- n_inputs, 3, number of input channels (>= 2).
- width, 4, data width of each input channel.
- depth, 4, entries per input FIFO (>= 2; need not be a power of two).
- out_width, 4, output data width (1 .. width + $clog2(n_inputs)).
- saturate, 0, overflow mode when out_width < full precision: 0 = wrap (keep low out_width bits), 1 = clamp to all-ones.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  n_inputs  per-channel valid.
- in_ready  output  n_inputs  per-channel ready.
- in_data  input  n_inputs*width  channel i at bits [i*width +: width].
- out_valid  output  1  sum valid.
- out_ready  input  1  sum ready.
- out_data  output  out_width  sum.

Behaviour:
- Reset (async, immediate on rst rise):
  - All FIFOs empty; double buffer empty.
  - out_valid = 0; out_data = 0.
  - in_ready = all ones once FIFOs are empty; in_ready is 0 while rst is high.
- Transfer rule: a transfer occurs when valid & ready are both high at a posedge. Producers may hold valid without waiting for ready.
- in_ready[i] = ~fifo_full[i]. It is driven only from registered state: no combinational path from out_ready or from other channels' valids. A full FIFO does not accept a push in the same cycle it pops.
- Channels fill independently; a stalled channel never blocks the others until their own FIFOs fill.
- Join fires when all FIFOs are non-empty and the double buffer holds fewer than 2 entries, or holds 2 entries with an output transfer in the same cycle. On fire, exactly one entry is popped from every FIFO and the sum is pushed.
- Arithmetic:
  - Unsigned sum computed at full precision, width + $clog2(n_inputs) bits.
  - If out_width is smaller: saturate=0 takes the low bits; saturate=1 yields 2^out_width - 1 whenever full-precision sum >= 2^out_width.
- Double buffer:
  - Two registered entries, FIFO order.
  - out_valid = buffer non-empty; out_data = head entry.
  - Pop on out_valid & out_ready. Simultaneous push and pop is allowed.
- Latency and throughput:
  - Input transferred at edge t is summed at edge t+1 (if all other channels are present and the buffer has room) and is visible on out_valid/out_data after edge t+1.
  - Minimum input-to-output latency: 2 edges.
  - Sustained throughput: 1 sum/cycle with all in_valid = 1 and out_ready = 1.
- Ordering: the k-th output equals the sum of the k-th accepted element of every channel.
- Capacity: with out_ready = 0, each channel accepts at most depth + 2 elements before in_ready drops.
- Reset mid-operation: all buffered data is discarded and no stale sum appears after rst falls.
- out_data is undefined-free: it holds its last value when out_valid = 0. The bench must not check it in that state.

Decomposition:
- Package n_way_sum_pkg holds:
  - function sum_full_width (n_inputs, width) returning width + $clog2(n_inputs);
  - the saturation helper function.
- Sub-module flip_flop_fifo_with_counter (width, depth): registered storage, wrap-around pointers, occupancy counter, full/empty. Instantiated n_inputs times in a generate loop.
- Double buffer, join logic and adder tree stay in the top module.

Test Plan (n_inputs=3, width=4, depth=4, out_width=4 unless stated):
- Reset: rst pulsed asynchronously between edges -> out_valid=0 immediately; in_ready=3'b111 after release; no output transfers.
- Back-to-back: all valid, data 1,2,3, out_ready=1 -> first out_valid two edges after first accept with out_data=6, then one sum per cycle, 20 sums in 22 cycles.
- Overflow: data 15,15,15 -> saturate=0 gives out_data=4'hD; saturate=1 gives 4'hF; with out_width=6, saturate=0 gives 6'd45.
- Missing channel: channels 0,1 valid, channel 2 idle -> after 4 accepts in_ready[1:0]=0, out_valid=0. Then enable channel 2 -> 4 sums drain in order and in_ready recovers.
- Backpressure: all valid, out_ready=0 -> exactly 6 accepts per channel, then in_ready=0 and out_valid=1 held. Set out_ready=1 -> 6 correct sums in order, no loss or duplication.
- Random: random valids and out_ready, 100 transfers per channel, scoreboard per-channel queues -> all sums match and no residue in the model queues at end.
